// File: rtl/l2_arbiter.sv
// l2_arbiter: shares one unified L2 port between the L1 I-cache and L1 D-cache.
// One requester is granted at a time; the grant is held until the L2 returns
// resp, and the arbiter then always passes through one IDLE cycle before the
// next grant (bus turnaround).
// Optional feature: define L2_ARB_ROUND_ROBIN_EN to break I/D ties in favour of
// the requester not served last; otherwise D always wins a tie.
module l2_arbiter #(
   parameter int unsigned ADDR_W = 16,
   parameter int unsigned LINE_W = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   // I-cache side
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_resp,
   output logic [LINE_W-1:0] i_rdata,
   // D-cache side
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_resp,
   output logic [LINE_W-1:0] d_rdata,
   // L2 side
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic              l2_resp,
   input  logic [LINE_W-1:0] l2_rdata,
   output logic [1:0]        grant
);

   typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

   state_e              state_q, state_d;
   logic [LINE_W-1:0]   i_rdata_q, d_rdata_q;
   logic                i_pend, d_pend;
   logic                d_wins_tie;

   assign i_pend = i_read;
   assign d_pend = d_read | d_write;

`ifdef L2_ARB_ROUND_ROBIN_EN
   // 1 when D completed the most recent transaction; resets to I.
   logic last_d_q;

   // Record which requester completed the most recent L2 transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_d_q <= 1'b0;
      end else if (l2_resp && (state_q != StIdle)) begin
         last_d_q <= (state_q == StGntD);
      end
   end

   assign d_wins_tie = ~last_d_q;
`else
   assign d_wins_tie = 1'b1;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: arbitrate only from IDLE, leave a grant only on l2_resp.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (d_pend && i_pend) begin
               state_d = d_wins_tie ? StGntD : StGntI;
            end else if (d_pend) begin
               state_d = StGntD;
            end else if (i_pend) begin
               state_d = StGntI;
            end
         end
         StGntI, StGntD: begin
            if (l2_resp) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // L2 request muxing and response routing to the granted requester.
   always_comb begin
      grant    = 2'b00;
      l2_read  = 1'b0;
      l2_write = 1'b0;
      l2_addr  = '0;
      l2_wdata = '0;
      i_resp   = 1'b0;
      d_resp   = 1'b0;
      unique case (state_q)
         StGntI: begin
            grant   = 2'b01;
            l2_read = i_read;
            l2_addr = i_addr;
            i_resp  = l2_resp;
         end
         StGntD: begin
            grant    = 2'b10;
            // A simultaneous read and write is treated as a write.
            l2_read  = d_read & ~d_write;
            l2_write = d_write;
            l2_addr  = d_addr;
            l2_wdata = d_wdata;
            d_resp   = l2_resp;
         end
         default: ;
      endcase
   end

   // Capture returned lines so each requester keeps its last line.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         if (i_resp) i_rdata_q <= l2_rdata;
         if (d_resp) d_rdata_q <= l2_rdata;
      end
   end

   // The line is also passed straight through in the resp cycle.
   assign i_rdata = i_resp ? l2_rdata : i_rdata_q;
   assign d_rdata = d_resp ? l2_rdata : d_rdata_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// tb_l2_arbiter: directed-vector bench for l2_arbiter with hand-computed
// expectations. Inputs change 1 time unit after the rising edge and outputs
// are checked a further time unit later, well away from the next edge.
module tb_l2_arbiter;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned LINE_W = 128;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic              i_resp;
   logic [LINE_W-1:0] i_rdata;
   logic              d_read, d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic              d_resp;
   logic [LINE_W-1:0] d_rdata;
   logic              l2_read, l2_write;
   logic [ADDR_W-1:0] l2_addr;
   logic [LINE_W-1:0] l2_wdata;
   logic              l2_resp;
   logic [LINE_W-1:0] l2_rdata;
   logic [1:0]        grant;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   localparam logic [LINE_W-1:0] LineA5 = {16{8'hA5}};
   localparam logic [LINE_W-1:0] LineDb = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
   localparam logic [LINE_W-1:0] Line3c = 128'h3C3C_0000_1111_2222_3333_4444_5555_6666;
   localparam logic [LINE_W-1:0] Line77 = 128'h7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE;
   localparam logic [LINE_W-1:0] Line19 = 128'h1919_2828_3737_4646_5555_6464_7373_8282;
   localparam logic [LINE_W-1:0] Line0f = 128'h0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F_0F0F;

   always #5 clk = ~clk;

   l2_arbiter #(
      .ADDR_W(ADDR_W),
      .LINE_W(LINE_W)
   ) u_dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_read  (i_read),
      .i_addr  (i_addr),
      .i_resp  (i_resp),
      .i_rdata (i_rdata),
      .d_read  (d_read),
      .d_write (d_write),
      .d_addr  (d_addr),
      .d_wdata (d_wdata),
      .d_resp  (d_resp),
      .d_rdata (d_rdata),
      .l2_read (l2_read),
      .l2_write(l2_write),
      .l2_addr (l2_addr),
      .l2_wdata(l2_wdata),
      .l2_resp (l2_resp),
      .l2_rdata(l2_rdata),
      .grant   (grant)
   );

   task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                           input logic [LINE_W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Advance one edge, then leave room before touching inputs.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive an L2 completion for one cycle with the given line.
   task automatic l2_pulse(input logic [LINE_W-1:0] line);
      l2_resp  = 1'b1;
      l2_rdata = line;
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      i_read = 1'b0; i_addr = '0;
      d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
      l2_resp = 1'b0; l2_rdata = '0;
      #12;
      check_eq("rst_grant", grant, 2'b00);
      check_eq("rst_l2_rw", {l2_read, l2_write}, 2'b00);
      check_eq("rst_l2_addr", l2_addr, 0);
      check_eq("rst_l2_wdata", l2_wdata, 0);
      check_eq("rst_resp", {i_resp, d_resp}, 2'b00);
      check_eq("rst_rdata", i_rdata | d_rdata, 0);
      rst_n = 1'b1;
      tick();

      // Single I read, L2 answers three cycles into the grant.
      i_read = 1'b1; i_addr = 16'h1230;
      #1 check_eq("i_wait_grant", grant, 2'b00);
      tick();
      check_eq("i_grant", grant, 2'b01);
      check_eq("i_l2_rw", {l2_read, l2_write}, 2'b10);
      check_eq("i_l2_addr", l2_addr, 16'h1230);
      check_eq("i_l2_wdata", l2_wdata, 0);
      tick(); tick();
      check_eq("i_hold_noresp", i_resp, 1'b0);
      l2_pulse(LineA5);
      check_eq("i_resp", {i_resp, d_resp}, 2'b10);
      check_eq("i_rdata_thru", i_rdata, LineA5);
      check_eq("i_d_rdata_hold", d_rdata, 0);
      tick();
      i_read = 1'b0; l2_resp = 1'b0; l2_rdata = '0;
      #1 check_eq("i_done_grant", grant, 2'b00);
      check_eq("i_rdata_held", i_rdata, LineA5);

      // D write-back.
      d_write = 1'b1; d_addr = 16'h4440; d_wdata = LineDb;
      tick();
      check_eq("dw_grant", grant, 2'b10);
      check_eq("dw_l2_rw", {l2_read, l2_write}, 2'b01);
      check_eq("dw_l2_addr", l2_addr, 16'h4440);
      check_eq("dw_l2_wdata", l2_wdata, LineDb);
      tick();
      l2_pulse(Line3c);
      check_eq("dw_resp", {i_resp, d_resp}, 2'b01);
      check_eq("dw_i_rdata_hold", i_rdata, LineA5);
      tick();
      d_write = 1'b0; d_wdata = '0; l2_resp = 1'b0;
      #1 check_eq("dw_done_grant", grant, 2'b00);
      check_eq("dw_d_rdata_cap", d_rdata, Line3c);

      // Read+write together counts as a write.
      d_read = 1'b1; d_write = 1'b1; d_addr = 16'h0010; d_wdata = Line0f;
      tick();
      check_eq("drw_l2_rw", {l2_read, l2_write}, 2'b01);
      l2_pulse('0);
      tick();
      d_read = 1'b0; d_write = 1'b0; l2_resp = 1'b0;

      // Restart so the round-robin pointer is back at its reset value (I).
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      tick();

      // Simultaneous requests: D wins the first tie in both builds.
      i_read = 1'b1; i_addr = 16'h2000;
      d_read = 1'b1; d_addr = 16'h3000;
      tick();
      check_eq("tie1_grant", grant, 2'b10);
      check_eq("tie1_l2_addr", l2_addr, 16'h3000);
      l2_pulse(Line77);
      check_eq("tie1_resp", {i_resp, d_resp}, 2'b01);
      tick();
      l2_resp = 1'b0;
      // D re-requests straight away, forming a second tie in this IDLE cycle.
      d_addr = 16'h3100;
      #1 check_eq("tie_gap_grant", grant, 2'b00);
      tick();
`ifdef L2_ARB_ROUND_ROBIN_EN
      check_eq("tie2_grant_rr", grant, 2'b01);
      l2_pulse(Line19);
      check_eq("tie2_i_resp", {i_resp, d_resp}, 2'b10);
      tick();
      l2_resp = 1'b0; i_read = 1'b0;
      tick();
      check_eq("tie2_then_d", grant, 2'b10);
      l2_pulse(Line0f);
      tick();
      l2_resp = 1'b0; d_read = 1'b0;
`else
      check_eq("tie2_grant_fixed", grant, 2'b10);
      check_eq("tie2_l2_addr", l2_addr, 16'h3100);
      l2_pulse(Line0f);
      tick();
      l2_resp = 1'b0; d_read = 1'b0;
      #1 check_eq("tie2_gap", grant, 2'b00);
      tick();
      check_eq("tie2_then_i", grant, 2'b01);
      check_eq("tie2_i_addr", l2_addr, 16'h2000);
      l2_pulse(Line19);
      check_eq("tie2_i_resp", {i_resp, d_resp}, 2'b10);
      tick();
      l2_resp = 1'b0; i_read = 1'b0;
`endif
      #1 check_eq("tie_i_rdata", i_rdata, Line19);
      check_eq("tie_d_rdata", d_rdata, Line0f);

      // Late arrival of D during an I grant.
      i_read = 1'b1; i_addr = 16'h5550;
      tick();
      check_eq("late_i_grant", grant, 2'b01);
      d_read = 1'b1; d_addr = 16'h6660;
      tick();
      check_eq("late_i_held", grant, 2'b01);
      check_eq("late_l2_addr", l2_addr, 16'h5550);
      l2_pulse(LineA5);
      check_eq("late_i_resp", {i_resp, d_resp}, 2'b10);
      tick();
      i_read = 1'b0; l2_resp = 1'b0;
      #1 check_eq("late_gap", grant, 2'b00);
      tick();
      check_eq("late_d_grant", grant, 2'b10);
      check_eq("late_d_addr", l2_addr, 16'h6660);
      l2_pulse(Line77);
      tick();
      d_read = 1'b0; l2_resp = 1'b0;

      // Asynchronous reset in the middle of a D grant.
      d_read = 1'b1; d_addr = 16'h7770;
      tick();
      check_eq("rst_mid_pre", grant, 2'b10);
      #1 rst_n = 1'b0;
      l2_resp = 1'b1; l2_rdata = Line3c;
      #1 check_eq("rst_mid_grant", grant, 2'b00);
      check_eq("rst_mid_l2_read", l2_read, 1'b0);
      check_eq("rst_mid_no_resp", d_resp, 1'b0);
      check_eq("rst_mid_d_rdata", d_rdata, 0);
      l2_resp = 1'b0;
      #1 rst_n = 1'b1;
      tick();
      check_eq("rst_regrant", grant, 2'b10);
      check_eq("rst_regrant_rd", l2_read, 1'b1);
      l2_pulse(Line19);
      tick();
      d_read = 1'b0; l2_resp = 1'b0;

      // Stray l2_resp while IDLE is ignored.
      tick();
      l2_pulse(Line0f);
      check_eq("stray_resp", {i_resp, d_resp}, 2'b00);
      tick();
      l2_resp = 1'b0;
      #1 check_eq("stray_grant", grant, 2'b00);
      check_eq("stray_i_rdata", i_rdata, 0);
      check_eq("stray_d_rdata", d_rdata, Line19);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/l2_arbiter.md
Name: l2_arbiter

Overview:
- Two-requester arbiter that shares the single unified L2 cache port between the L1 instruction cache (port I) and the L1 data cache (port D).
- Sits between both L1 miss interfaces and the L2 controller. Each side uses a read/write/resp handshake with 128-bit lines.
- Grants one requester at a time and holds the grant until the L2 returns resp. Data and response are routed only to the granted requester.

Parameters:
- ADDR_W, 16, byte-address width of all ports.
- LINE_W, 128, cache-line data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I-cache line read request
- i_addr  in  ADDR_W  I-cache request address
- i_resp  out  1  one-cycle completion pulse to the I-cache
- i_rdata  out  LINE_W  line returned to the I-cache
- d_read  in  1  D-cache line read request
- d_write  in  1  D-cache line write-back request
- d_addr  in  ADDR_W  D-cache request address
- d_wdata  in  LINE_W  D-cache write-back line
- d_resp  out  1  one-cycle completion pulse to the D-cache
- d_rdata  out  LINE_W  line returned to the D-cache
- l2_read  out  1  read request to the L2
- l2_write  out  1  write request to the L2
- l2_addr  out  ADDR_W  address to the L2
- l2_wdata  out  LINE_W  write data to the L2
- l2_resp  in  1  L2 completion pulse
- l2_rdata  in  LINE_W  L2 read data, valid while l2_resp=1
- grant  out  2  current grant: 00 none, 01 I, 10 D

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D. Reset (rst_n=0, asynchronous) forces IDLE.
- Reset values: all resp 0, l2_read=l2_write=0, grant=00, l2_addr=0, l2_wdata=0, last-served pointer = I.
- Requester pending:
  - I is pending when i_read=1.
  - D is pending when d_read|d_write=1.
  - If d_read and d_write are both 1, D is treated as a write.
- IDLE transitions, evaluated at the clock edge:
  - Only I pending -> GNT_I.
  - Only D pending -> GNT_D.
  - Both pending -> GNT_D (fixed D priority; see Optional Feature).
  - Neither pending -> stay in IDLE.
- While in GNT_x:
  - l2_addr, l2_read and l2_write follow requester x combinationally.
  - l2_wdata follows d_wdata in GNT_D; it is 0 in GNT_I.
  - For I, l2_write is always 0.
- l2_resp=1 while in GNT_x:
  - x_resp=1 in that same cycle (combinational); x_rdata=l2_rdata.
  - Next state is IDLE.
  - The other requester's resp stays 0, and its rdata is held at its last value.
- Bus-turnaround gap: a back-to-back grant is never issued in the cycle of l2_resp. Minimum one IDLE cycle between transactions.
- Latency:
  - Request to L2 request: 1 cycle (one IDLE cycle sampling the request, then the GNT state drives the L2).
  - L2 resp to requester resp: 0 cycles.
- In IDLE, l2_read=l2_write=0 and all resp=0. An l2_resp arriving in IDLE is ignored.
- Requesters hold read/write/addr stable until their resp. If a requester drops its request mid-grant, the grant is still held until l2_resp. During that time l2_read/l2_write follow the dropped inputs (0).
- Reset mid-transaction: the transaction is abandoned and state returns to IDLE immediately. The L2 controller shares rst_n and is reset in the same cycle.
- rdata registers: i_rdata and d_rdata are captured on l2_resp for the granted port and also driven through combinationally in the resp cycle. Reset value is 0.

Optional Feature:
- Macro L2_ARB_ROUND_ROBIN_EN.
- Defined:
  - When both requesters are pending in IDLE, grant the one not served last.
  - The last-served pointer updates on each completed l2_resp; its reset value is I, so D wins the first tie.
- Undefined:
  - Fixed D priority on every tie.
  - The pointer logic is not built.

Test Plan:
- Single I read: i_read=1, i_addr=16'h1230; L2 resp after 3 cycles with l2_rdata=128'hA5..A5. Required: grant=01 and l2_read=1 one cycle after request; l2_addr=16'h1230; i_resp=1 with i_rdata=A5..A5 in the l2_resp cycle; d_resp stays 0.
- D write-back: d_write=1, d_addr=16'h4440, d_wdata=128'hDEAD...BEEF. Required: l2_write=1, l2_wdata matches d_wdata; d_resp pulse on l2_resp; then grant=00.
- Simultaneous requests: i_read and d_read both asserted in the same cycle. Without the macro: D served first, then one IDLE cycle, then I. With the macro: D first, I second, then on the next tie I wins.
- Late arrival: d_read asserted while GNT_I is in progress. Required: the I grant is held until its l2_resp; D is granted after one IDLE cycle.
- Async reset mid-grant: rst_n=0 in the middle of GNT_D, between edges. Required: grant=00 and l2_read=0 immediately; no d_resp produced; after release, a fresh d_read is regranted normally.
- Stray l2_resp while IDLE: required no i_resp or d_resp and no state change.
